cmd_frame_decoder: RTL and testbench
====================================

# cmd_frame_decoder

Consumes the decoded byte stream from `cobs_decode` (`o_data`/`o_valid`/`o_last`, ready-back) and assembles fixed-length register-write commands. Each command is an address, a data word and an XOR checksum. Validated commands go out on a valid/ready port to the register bank that sets DDS tuning and other control fields. Malformed frames are dropped whole and reported through error pulses and a saturating error counter.

## Interface
Parameters:
- `AW`, 8: address width in bits; must be a multiple of 8.
- `DW`, 24: data width in bits; must be a multiple of 8.
- Derived: `AB = AW/8`, `DB = DW/8`, `FRAME_BYTES = AB + DB + 1` (5 at defaults).

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `i_data`  in  8  decoded byte.
- `i_valid`  in  1  byte valid.
- `o_ready`  out  1  decoder may present the next byte.
- `i_last`  in  1  byte is the final byte of its frame.
- `o_addr`  out  AW  command address.
- `o_data`  out  DW  command data.
- `o_valid`  out  1  command valid.
- `i_ready`  in  1  consumer accepts the command.
- `o_err_len`  out  1  one-cycle pulse: wrong frame length.
- `o_err_sum`  out  1  one-cycle pulse: checksum mismatch.
- `o_err_cnt`  out  16  total errors, saturating at 0xFFFF.

## Operation
- A byte is accepted on a cycle where `i_valid && o_ready`. A command is taken on a cycle where `o_valid && i_ready`.
- Frame byte order: address MSB first, then data MSB first, then a checksum byte.
  - The checksum is the XOR of all address and data bytes.
- State machine:
  - **RECV**:
    - `o_ready = 1`.
    - Each accepted byte shifts into a `(AW+DW)`-bit shift register, XORs into a running checksum and increments byte index `idx`.
  - **DROP**:
    - `o_ready = 1`.
    - Accepted bytes are discarded until `i_last`.
  - **HOLD**:
    - `o_ready = 0` and `o_valid = 1`.
    - `o_addr`/`o_data` are held stable.
- Transitions from RECV, evaluated on the accepted byte:
  - `i_last` with `idx < FRAME_BYTES-1` (short frame): pulse `o_err_len`, clear `idx` and the checksum, stay in RECV.
  - `idx == FRAME_BYTES-1` with `i_last`:
    - If the byte equals the running checksum: load `o_addr`/`o_data` from the shift register and go to HOLD.
    - Otherwise pulse `o_err_sum` and return to RECV.
    - In both cases clear `idx` and the checksum.
  - `idx == FRAME_BYTES-1` without `i_last` (long frame): go to DROP.
- DROP: on the accepted byte with `i_last`, pulse `o_err_len`, clear `idx` and the checksum, go to RECV.
- HOLD: when `i_ready` is sampled high, deassert `o_valid` and go to RECV.
- `o_err_cnt` increments on each cycle where `o_err_len` or `o_err_sum` pulses; it holds at 0xFFFF. The two pulses are never asserted together.
- A single-byte frame (`i_last` on byte 0) is a short frame.
- Reset mid-frame discards the partial frame. Reset during HOLD drops the pending command.

## Timing
- Reset values:
  - State is RECV, so `o_ready = 1`.
  - `o_valid = 0`, `o_addr = 0`, `o_data = 0`.
  - `o_err_len = 0`, `o_err_sum = 0`, `o_err_cnt = 0`.
  - `idx = 0`, checksum `= 0`.
- `o_ready` is a combinational decode of registered state only; it has no path from `i_valid`.
- Latency: `o_valid` rises on the cycle after the checksum byte is accepted.
- `o_valid` may stay high for any number of cycles. `o_addr`/`o_data` must not change while `o_valid` is high.
- Back-to-back throughput:
  - With `i_ready` held high, HOLD lasts 1 cycle.
  - The first byte of the next frame is accepted on the cycle after the command is taken.
  - One command therefore needs at least `FRAME_BYTES + 1` cycles.
- Error pulses are registered and fire on the cycle after the offending byte is accepted.
- `i_valid` gaps at any point in a frame are allowed; state is held while `i_valid` is low.

## Test plan
- Good frame, AW=8/DW=24: bytes 12 AB CD EF 9B, `i_last` on 9B, `i_ready` = 1 → one cycle later `o_valid = 1`, `o_addr = 0x12`, `o_data = 0xABCDEF`; no error pulses.
- Backpressure: same frame, `i_ready = 0` for 10 cycles → `o_valid` and `o_ready = 0` stay held with stable outputs for 10 cycles; command is taken on cycle 11, then `o_ready` returns to 1.
- Checksum error: bytes 12 AB CD EF 9C with `i_last` → `o_err_sum` pulses once, `o_err_cnt = 1`, `o_valid` never rises; a following good frame decodes correctly.
- Short frame: bytes 12 AB with `i_last` on AB → `o_err_len` pulses; then 12 AB CD EF 9B decodes to 0x12 / 0xABCDEF.
- Long frame: 7 bytes 12 AB CD EF 9B 00 00, `i_last` on the 7th → no `o_valid`, exactly one `o_err_len` pulse, `o_err_cnt` increments by 1; the next good frame decodes correctly.
- Reset asserted after 3 bytes of a frame, then released → all outputs at reset values; a fresh good frame decodes with `o_err_cnt = 0`.

Source files
------------

// File: rtl/cmd_frame_decoder.sv
// Assembles fixed-length register-write commands (address, data, XOR checksum)
// from a decoded byte stream; malformed frames are dropped and counted.
module cmd_frame_decoder #(
    parameter int AW = 8,
    parameter int DW = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    i_data,
    input  logic          i_valid,
    output logic          o_ready,
    input  logic          i_last,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data,
    output logic          o_valid,
    input  logic          i_ready,
    output logic          o_err_len,
    output logic          o_err_sum,
    output logic [15:0]   o_err_cnt
);

    localparam int FRAME_BYTES = AW / 8 + DW / 8 + 1;
    localparam int IW          = $clog2(FRAME_BYTES);
    localparam logic [IW-1:0] LAST_IDX = IW'(FRAME_BYTES - 1);

    typedef enum logic [1:0] {RECV, DROP, HOLD} state_t;

    state_t               state, state_nxt;
    logic [AW+DW-1:0]     shreg;
    logic [7:0]           csum;
    logic [IW-1:0]        idx;
    logic                 accept;
    logic                 at_sum;
    logic                 sum_ok;

    assign accept = i_valid && o_ready;
    assign at_sum = (idx == LAST_IDX);
    assign sum_ok = (i_data == csum);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RECV;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RECV: begin
                if (accept && at_sum) begin
                    if (!i_last)     state_nxt = DROP;
                    else if (sum_ok) state_nxt = HOLD;
                    else             state_nxt = RECV;
                end
            end
            DROP:    if (accept && i_last) state_nxt = RECV;
            HOLD:    if (i_ready) state_nxt = RECV;
            default: state_nxt = RECV;
        endcase
    end

    always_comb begin
        o_ready = (state != HOLD);
        o_valid = (state == HOLD);
    end

    // idx stays at the checksum position while dropping an over-long frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shreg     <= '0;
            csum      <= '0;
            idx       <= '0;
            o_addr    <= '0;
            o_data    <= '0;
            o_err_len <= 1'b0;
            o_err_sum <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            o_err_len <= 1'b0;
            o_err_sum <= 1'b0;
            if ((o_err_len || o_err_sum) && (o_err_cnt != '1))
                o_err_cnt <= o_err_cnt + 16'd1;
            if (accept) begin
                case (state)
                    RECV: begin
                        if (at_sum) begin
                            if (i_last) begin
                                idx  <= '0;
                                csum <= '0;
                                if (sum_ok) {o_addr, o_data} <= shreg;
                                else        o_err_sum <= 1'b1;
                            end
                        end else if (i_last) begin
                            o_err_len <= 1'b1;
                            idx       <= '0;
                            csum      <= '0;
                        end else begin
                            shreg <= {shreg[AW+DW-9:0], i_data};
                            csum  <= csum ^ i_data;
                            idx   <= idx + 1'b1;
                        end
                    end
                    DROP: begin
                        if (i_last) begin
                            o_err_len <= 1'b1;
                            idx       <= '0;
                            csum      <= '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmd_frame_decoder.sv
// Self-checking bench for cmd_frame_decoder: frame-level reference model plus
// directed literal checks and randomized frames with gaps and backpressure.
module tb_cmd_frame_decoder;

    localparam int AW = 8;
    localparam int DW = 24;
    localparam int AB = AW / 8;
    localparam int DB = DW / 8;
    localparam int FB = AB + DB + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [7:0]    i_data = '0;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic          i_last = 1'b0;
    logic [AW-1:0] o_addr;
    logic [DW-1:0] o_data;
    logic          o_valid;
    logic          i_ready = 1'b0;
    logic          o_err_len;
    logic          o_err_sum;
    logic [15:0]   o_err_cnt;

    int checks = 0;
    int fails  = 0;
    int rdy_mode = 1;
    int gap_max  = 0;

    always #5 clk = ~clk;

    cmd_frame_decoder #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .i_data(i_data), .i_valid(i_valid), .o_ready(o_ready), .i_last(i_last),
        .o_addr(o_addr), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
        .o_err_len(o_err_len), .o_err_sum(o_err_sum), .o_err_cnt(o_err_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a frame is judged only by its byte count and XOR.
    logic          m_valid = 1'b0;
    logic [AW-1:0] m_addr  = '0;
    logic [DW-1:0] m_data  = '0;
    logic          m_len   = 1'b0;
    logic          m_sum   = 1'b0;
    logic [15:0]   m_cnt   = '0;
    logic [7:0]    m_frame[$];
    logic [7:0]    m_x;
    logic          m_pulsed;

    always @(negedge clk) begin
        if (!rst) begin
            m_valid = 1'b0; m_addr = '0; m_data = '0;
            m_len = 1'b0; m_sum = 1'b0; m_cnt = '0;
            m_frame.delete();
        end
        chk("ready", o_ready, !m_valid);
        chk("valid", o_valid, m_valid);
        chk("addr", o_addr, m_addr);
        chk("data", o_data, m_data);
        chk("err_len", o_err_len, m_len);
        chk("err_sum", o_err_sum, m_sum);
        chk("err_cnt", o_err_cnt, m_cnt);
        if (rst) begin
            m_pulsed = m_len | m_sum;
            m_len = 1'b0;
            m_sum = 1'b0;
            if (m_pulsed && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_valid) begin
                if (i_ready) m_valid = 1'b0;
            end else if (i_valid) begin
                m_frame.push_back(i_data);
                if (i_last) begin
                    if (m_frame.size() != FB) begin
                        m_len = 1'b1;
                    end else begin
                        m_x = '0;
                        for (int k = 0; k < FB - 1; k++) m_x = m_x ^ m_frame[k];
                        if (m_x == m_frame[FB-1]) begin
                            m_valid = 1'b1;
                            m_addr = '0;
                            m_data = '0;
                            for (int k = 0; k < AB; k++)
                                m_addr = (m_addr << 8) | AW'(m_frame[k]);
                            for (int k = AB; k < AB + DB; k++)
                                m_data = (m_data << 8) | DW'(m_frame[k]);
                        end else begin
                            m_sum = 1'b1;
                        end
                    end
                    m_frame.delete();
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0:       i_ready = 1'b0;
                1:       i_ready = 1'b1;
                default: i_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic send_byte(input logic [7:0] b, input logic last);
        int   waited;
        logic r;
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
                i_valid = 1'b0;
                @(posedge clk);
                #1;
            end
        end
        i_valid = 1'b1;
        i_data  = b;
        i_last  = last;
        waited  = 0;
        forever begin
            @(negedge clk);
            r = o_ready;
            @(posedge clk);
            #1;
            if (r) break;
            waited++;
            if (waited > 60) begin
                checks++;
                fails++;
                $display("FAIL byte_accept_timeout: got no o_ready expected acceptance at %0t", $time);
                break;
            end
        end
        i_valid = 1'b0;
        i_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b[$]);
        for (int i = 0; i < b.size(); i++) send_byte(b[i], i == b.size() - 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready;
        int w;
        w = 0;
        while (!o_ready && w < 40) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("ready_return", o_ready, 1'b1);
    endtask

    task automatic good_frame_literal(input string tag);
        logic [7:0] f[$];
        f = '{8'h12, 8'hAB, 8'hCD, 8'hEF, 8'h9B};
        send_frame(f);
        chk({tag, "_valid"}, o_valid, 1'b1);
        chk({tag, "_addr"}, o_addr, 32'h12);
        chk({tag, "_data"}, o_data, 32'hABCDEF);
        chk({tag, "_nolen"}, o_err_len, 1'b0);
        chk({tag, "_nosum"}, o_err_sum, 1'b0);
        wait_ready();
    endtask

    initial begin
        logic [7:0] f[$];
        int kind, len;
        logic [7:0] x;

        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", o_ready, 1'b1);
        chk("rst_valid", o_valid, 1'b0);
        chk("rst_cnt", o_err_cnt, 16'd0);
        rst = 1'b1;
        idle(2);

        good_frame_literal("good");
        idle(2);

        rdy_mode = 0;
        f = '{8'h12, 8'hAB, 8'hCD, 8'hEF, 8'h9B};
        send_frame(f);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_valid", o_valid, 1'b1);
            chk("bp_ready", o_ready, 1'b0);
            chk("bp_data", o_data, 32'hABCDEF);
        end
        rdy_mode = 1;
        wait_ready();
        chk("bp_taken", o_valid, 1'b0);
        idle(2);

        f = '{8'h12, 8'hAB, 8'hCD, 8'hEF, 8'h9C};
        send_frame(f);
        chk("sum_pulse", o_err_sum, 1'b1);
        idle(1);
        chk("sum_once", o_err_sum, 1'b0);
        chk("sum_cnt", o_err_cnt, 16'd1);
        chk("sum_novalid", o_valid, 1'b0);
        good_frame_literal("after_sum");

        f = '{8'h12, 8'hAB};
        send_frame(f);
        chk("short_pulse", o_err_len, 1'b1);
        idle(1);
        chk("short_cnt", o_err_cnt, 16'd2);
        good_frame_literal("after_short");

        f = '{8'h12, 8'hAB, 8'hCD, 8'hEF, 8'h9B, 8'h00, 8'h00};
        send_frame(f);
        chk("long_pulse", o_err_len, 1'b1);
        chk("long_novalid", o_valid, 1'b0);
        idle(1);
        chk("long_once", o_err_len, 1'b0);
        chk("long_cnt", o_err_cnt, 16'd3);
        good_frame_literal("after_long");

        send_byte(8'h12, 1'b0);
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        rst = 1'b0;
        idle(2);
        chk("mid_rst_cnt", o_err_cnt, 16'd0);
        chk("mid_rst_valid", o_valid, 1'b0);
        chk("mid_rst_addr", o_addr, 32'h0);
        rst = 1'b1;
        idle(1);
        good_frame_literal("after_rst");
        chk("after_rst_cnt", o_err_cnt, 16'd0);

        rdy_mode = 2;
        gap_max  = 2;
        for (int n = 0; n < 300; n++) begin
            f.delete();
            kind = $urandom_range(0, 3);
            if (kind <= 2) begin
                x = '0;
                for (int k = 0; k < FB - 1; k++) begin
                    f.push_back(8'($urandom));
                    x = x ^ f[k];
                end
                if (kind == 2) x = x ^ 8'($urandom_range(1, 255));
                f.push_back(x);
            end else begin
                len = ($urandom_range(0, 1) == 0) ? $urandom_range(1, FB - 1)
                                                  : $urandom_range(FB + 1, FB + 4);
                for (int k = 0; k < len; k++) f.push_back(8'($urandom));
            end
            send_frame(f);
        end

        rdy_mode = 1;
        gap_max  = 0;
        idle(5);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
